// File: rtl/div_seq_ctrl.sv
// Sequencing wrapper around a combinational unsigned restoring divider: sign handling, settle timing, handshakes.
// Optional early-out for |a| < |b| when DIV_SEQ_SKIP_EN is defined.
module div_seq_ctrl #(
  parameter int unsigned WIDTH         = 64,
  parameter int unsigned SETTLE_CYCLES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             is_signed,
  output logic [WIDTH-1:0] dv_a,
  output logic [WIDTH-1:0] dv_div,
  input  logic [WIDTH-1:0] dv_quo,
  input  logic [WIDTH-1:0] dv_r,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] quo,
  output logic [WIDTH-1:0] rem,
  output logic             div_by_zero
);

  localparam int unsigned CNT_W = 8;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_FAST,
    S_DONE
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               neg_quo_q, neg_quo_d;
  logic               neg_rem_q, neg_rem_d;
  logic               zero_q, zero_d;
  logic [WIDTH-1:0]   a_raw_q, a_raw_d;
  logic [WIDTH-1:0]   dv_a_q, dv_a_d;
  logic [WIDTH-1:0]   dv_div_q, dv_div_d;
  logic [WIDTH-1:0]   quo_q, quo_d;
  logic [WIDTH-1:0]   rem_q, rem_d;
  logic               out_valid_q, out_valid_d;
  logic               dbz_q, dbz_d;

  logic               a_neg, b_neg, b_zero;
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [WIDTH-1:0]   quo_fix, rem_fix;

  // Operand magnitudes; the most-negative value maps to 2^(WIDTH-1) unsigned.
  assign a_neg  = is_signed & op_a[WIDTH-1];
  assign b_neg  = is_signed & op_b[WIDTH-1];
  assign b_zero = (op_b == '0);
  assign a_mag  = a_neg ? (~op_a + WIDTH'(1)) : op_a;
  assign b_mag  = b_neg ? (~op_b + WIDTH'(1)) : op_b;

  // Sign correction of the sampled divider outputs.
  assign quo_fix = neg_quo_q ? (~dv_quo + WIDTH'(1)) : dv_quo;
  assign rem_fix = neg_rem_q ? (~dv_r + WIDTH'(1)) : dv_r;

`ifdef DIV_SEQ_SKIP_EN
  logic a_lt_b;
  assign a_lt_b = (a_mag < b_mag);
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      neg_quo_q   <= 1'b0;
      neg_rem_q   <= 1'b0;
      zero_q      <= 1'b0;
      a_raw_q     <= '0;
      dv_a_q      <= '0;
      dv_div_q    <= '0;
      quo_q       <= '0;
      rem_q       <= '0;
      out_valid_q <= 1'b0;
      dbz_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      neg_quo_q   <= neg_quo_d;
      neg_rem_q   <= neg_rem_d;
      zero_q      <= zero_d;
      a_raw_q     <= a_raw_d;
      dv_a_q      <= dv_a_d;
      dv_div_q    <= dv_div_d;
      quo_q       <= quo_d;
      rem_q       <= rem_d;
      out_valid_q <= out_valid_d;
      dbz_q       <= dbz_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    neg_quo_d   = neg_quo_q;
    neg_rem_d   = neg_rem_q;
    zero_d      = zero_q;
    a_raw_d     = a_raw_q;
    dv_a_d      = dv_a_q;
    dv_div_d    = dv_div_q;
    quo_d       = quo_q;
    rem_d       = rem_q;
    out_valid_d = out_valid_q;
    dbz_d       = dbz_q;

    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          neg_quo_d = (a_neg ^ b_neg) & ~b_zero;
          neg_rem_d = a_neg;
          zero_d    = b_zero;
          a_raw_d   = op_a;
          dv_a_d    = a_mag;
          dv_div_d  = b_mag;
          // Zero divisor (and, when enabled, trivially small dividends) skip the divider.
          if (b_zero) begin
            state_d = S_FAST;
`ifdef DIV_SEQ_SKIP_EN
          end else if (a_lt_b) begin
            state_d = S_FAST;
`endif
          end else begin
            cnt_d   = CNT_W'(SETTLE_CYCLES - 1);
            state_d = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (cnt_q == '0) begin
          quo_d       = quo_fix;
          rem_d       = rem_fix;
          out_valid_d = 1'b1;
          state_d     = S_DONE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_FAST: begin
        quo_d       = zero_q ? {WIDTH{1'b1}} : {WIDTH{1'b0}};
        rem_d       = a_raw_q;
        dbz_d       = zero_q;
        out_valid_d = 1'b1;
        state_d     = S_DONE;
      end
      S_DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          dbz_d       = 1'b0;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign in_ready    = (state_q == S_IDLE);
  assign dv_a        = dv_a_q;
  assign dv_div      = dv_div_q;
  assign quo         = quo_q;
  assign rem         = rem_q;
  assign out_valid   = out_valid_q;
  assign div_by_zero = dbz_q;

endmodule
